display_source_arbiter: RTL
===========================

// Module: display_source_arbiter
// PURPOSE
//  Parametrised selector choosing which of NUM_SRC operand/result sources drives the
//  7-segment path (BCD converter + sign digit). Last source to assert its load strobe
//  owns the display; the highest index wins on simultaneous strobes.
//  Adds features absent from the earlier selector: a valid/ready update handshake to
//  the BCD converter, an idle timeout that reverts to source 0, and a forced-select override.
// PARAMETERS
//  NUM_SRC   3    number of sources (>=2); 0=operand 1, 1=operand 2, 2=product by convention
//  DATA_W    16   magnitude width; narrower sources are zero-extended by the integrator
//  HOLD_CYC  0    cycles without any load before reverting to source 0; 0 = timeout disabled
//  SEL_W     $clog2(NUM_SRC)  derived, not overridable
// PORTS
//  clk          in   1                reset rst, asynchronous, active-high; clock clk
//  rst          in   1                asynchronous, active-high reset
//  src_data     in   NUM_SRC*DATA_W   packed magnitudes; source i at [i*DATA_W +: DATA_W]
//  src_sign     in   NUM_SRC          sign per source, 1 = negative
//  src_load     in   NUM_SRC          per-source "listo" strobe; level or pulse accepted
//  force_en     in   1                override: display source force_sel while high
//  force_sel    in   SEL_W            forced source index
//  disp_data    out  DATA_W           registered magnitude to the BCD converter
//  disp_sign    out  1                registered sign to the sign digit
//  disp_sel     out  SEL_W            currently selected source index
//  upd_valid    out  1                displayed word changed and not yet accepted
//  upd_ready    in   1                BCD converter idle, accepts an update
// BEHAVIOUR
//  Reset: sel=0, disp_data=0, disp_sign=0, disp_sel=0, upd_valid=0, ack word={0,0,0}, timer=0.
//  Selection, per rising edge, priority high->low:
//   1) force_en && force_sel<NUM_SRC -> sel<=force_sel; out-of-range force_sel ignored (sel held).
//   2) any src_load bit -> sel<=highest asserted index; timer cleared.
//   3) HOLD_CYC>0 && sel!=0 && timer==HOLD_CYC-1 -> sel<=0, timer cleared.
//   4) else sel held; timer increments while sel!=0 && HOLD_CYC>0, saturates, cleared when sel==0.
//  Timer does not run while force_en is high.
//  Data path: disp_data/disp_sign/disp_sel <= src_data/src_sign of the NEXT sel value,
//   every cycle (tracking). Latency = 1 clk from strobe or source change to outputs.
//  Handshake FSM (2 states):
//   IDLE: upd_valid=0; if {disp_sel,disp_sign,disp_data} != ack word -> PEND.
//   PEND: upd_valid=1; outputs may keep changing while pending (latest value wins);
//         on upd_valid&&upd_ready: ack word <= current {disp_sel,disp_sign,disp_data} -> IDLE.
//   upd_valid never drops without handshake, except via reset.
//   The consumer samples disp_* in the handshake cycle.
//   Change in the same cycle as the handshake: the ack word holds the sampled value, so the
//   new value re-raises upd_valid one cycle after return to IDLE.
//  Negative zero: disp_sign passes through unchanged; sign digit owner decides blanking.
//  Reset mid-PEND: upd_valid drops asynchronously; no update is owed after reset release.
// STRUCTURE
//  disp_pkg: typedef enum logic {ST_IDLE, ST_PEND} disp_upd_state_t; localparam SRC_OPER1=0,
//   SRC_OPER2=1, SRC_PRODUCT=2; shared by keypad/multiplier/top integration.
//  Sub-module display_hold_timer (params HOLD_CYC; in clr, run; out expire) holds the
//   timeout counter; sized $clog2(HOLD_CYC+1), tied off when HOLD_CYC==0.
//  Top holds the select logic, the output registers, the ack word and the FSM.
// TESTING (NUM_SRC=3, DATA_W=16, HOLD_CYC=8 unless noted; upd_ready=1 unless noted)
//  Reset, src0=0x0012 -> cycle 1 disp_data=0x0012, disp_sel=0; cycle 2 upd_valid=1 for 1 clk.
//  src_load=3'b011 in one cycle -> disp_sel=1 next cycle; then 3'b100 -> disp_sel=2, data=src2.
//  upd_ready=0, src1 changes 0x5->0x6->0x7 -> upd_valid stays 1; ready=1 -> accepted word 0x7.
//  Load src2, no further loads -> disp_sel=2 for 8 clk, then disp_sel=0 and one update issued.
//  force_en=1, force_sel=3 -> ignored, sel held; force_sel=1 with src_load=3'b100 -> disp_sel=1.
//  Assert rst while upd_valid=1 -> all outputs 0 immediately; no stale update after release.

Source files
------------

// File: rtl/disp_pkg.sv
// disp_pkg: handshake state type and source index names shared by display integration
package disp_pkg;
    typedef enum logic {ST_IDLE, ST_PEND} disp_upd_state_t;
    localparam int SRC_OPER1   = 0;
    localparam int SRC_OPER2   = 1;
    localparam int SRC_PRODUCT = 2;
endpackage

// File: rtl/display_source_arbiter_hold_timer.sv
// display_hold_timer: idle counter that flags when the selected source has gone quiet too long
module display_hold_timer #(
    parameter int HOLD_CYC = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic run,
    output logic expire
);
    if (HOLD_CYC == 0) begin : g_off
        logic unused;
        assign unused = ^{clk, rst, clr, run};
        assign expire = 1'b0;
    end else begin : g_on
        localparam int CW = $clog2(HOLD_CYC + 1);
        logic [CW-1:0] cnt;
        // count idle cycles, parking at the last value so expire stays visible
        always_ff @(posedge clk or posedge rst)
            if (rst) cnt <= '0;
            else if (clr) cnt <= '0;
            else if (run && cnt != CW'(HOLD_CYC - 1)) cnt <= cnt + 1'b1;
        assign expire = run && cnt == CW'(HOLD_CYC - 1);
    end
endmodule

// File: rtl/display_source_arbiter.sv
// display_source_arbiter: picks which source drives the 7-segment path and hands updates to the BCD converter
module display_source_arbiter
    import disp_pkg::*;
#(
    parameter  int NUM_SRC  = 3,
    parameter  int DATA_W   = 16,
    parameter  int HOLD_CYC = 0,
    localparam int SEL_W    = $clog2(NUM_SRC)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic [NUM_SRC-1:0]        src_sign,
    input  logic [NUM_SRC-1:0]        src_load,
    input  logic                      force_en,
    input  logic [SEL_W-1:0]          force_sel,
    output logic [DATA_W-1:0]         disp_data,
    output logic                      disp_sign,
    output logic [SEL_W-1:0]          disp_sel,
    output logic                      upd_valid,
    input  logic                      upd_ready
);
    logic [SEL_W-1:0]        sel_nxt, load_idx;
    logic                    any_load, force_ok, expire;
    logic [SEL_W+DATA_W:0]   word, ack;
    disp_upd_state_t         st, st_nxt;

    assign any_load = |src_load;
    assign force_ok = {1'b0, force_sel} < (SEL_W + 1)'(NUM_SRC);
    assign word     = {disp_sel, disp_sign, disp_data};

    // highest asserted strobe wins
    always_comb begin
        load_idx = '0;
        for (int i = 0; i < NUM_SRC; i++)
            if (src_load[i]) load_idx = SEL_W'(i);
    end

    // force overrides everything; an out-of-range force freezes the selection
    always_comb
        sel_nxt = force_en ? (force_ok ? force_sel : disp_sel)
                : any_load ? load_idx
                : expire   ? {SEL_W{1'b0}}
                : disp_sel;

    display_hold_timer #(.HOLD_CYC(HOLD_CYC)) u_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (disp_sel == '0 || (!force_en && (any_load || expire))),
        .run    (!force_en && disp_sel != '0),
        .expire (expire)
    );

    // outputs track the source chosen for the next cycle
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            disp_data <= '0;
            disp_sign <= 1'b0;
            disp_sel  <= '0;
        end else begin
            disp_data <= src_data[sel_nxt*DATA_W +: DATA_W];
            disp_sign <= src_sign[sel_nxt];
            disp_sel  <= sel_nxt;
        end

    // handshake state and the last word the consumer accepted
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            st  <= ST_IDLE;
            ack <= '0;
        end else begin
            st <= st_nxt;
            if (upd_valid && upd_ready) ack <= word;
        end

    // pending until the consumer takes whatever value is current
    always_comb begin
        upd_valid = st == ST_PEND;
        st_nxt    = upd_valid ? (upd_ready ? ST_IDLE : ST_PEND)
                  : (word != ack ? ST_PEND : ST_IDLE);
    end
endmodule
